// File: rtl/memory_pkg.sv
// Shared types and sizing helpers for the memory bank.
package memory_pkg;

  // Two-phase life cycle: clear the array, then serve requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Plain ceil(log2(n)). This is used for both the word-index width
  // (from DEPTH) and the byte-offset width (from WIDTH/8). It returns
  // 0 for a one-byte word, which means there are no offset bits at all.
  function automatic int unsigned index_bits(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Two-entry response buffer with valid/ready on both sides.
// Fullness depends only on the stored count, so in_ready never combinationally follows out_ready.
module rsp_fifo #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] entries [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  // Handshakes and head presentation; an empty buffer drives zeros.
  always_comb begin
    in_ready  = (count != 2'd2);
    out_valid = (count != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = out_valid ? entries[rd_ptr] : '0;
  end

  // Pointer and occupancy bookkeeping; reset discards anything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage only; contents past the head are never visible, so no reset.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/memory_bank.sv
// Byte-strobed word memory with a clearing phase and buffered read responses.
module memory_bank
  import memory_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_req_valid,
  output logic               rd_req_ready,
  input  logic [31:0]        rd_req_addr,
  output logic               rd_rsp_valid,
  input  logic               rd_rsp_ready,
  output logic [WIDTH-1:0]   rd_rsp_data,
  output logic               rd_rsp_err,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [31:0]        wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_strb,
  output logic               wr_err,
  output logic               init_done
);

  localparam int          BYTES    = WIDTH / 8;
  localparam int          OFS      = int'(index_bits(BYTES));
  localparam int          AW       = int'(index_bits(DEPTH));
  localparam logic [31:0] LOW_MASK = 32'(BYTES - 1);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  state_t             state;
  state_t             state_next;
  logic [AW-1:0]      init_idx;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               run;
  logic               fifo_in_ready;
  logic               rd_fire;
  logic               wr_fire;
  logic [31:0]        rd_word;
  logic [31:0]        wr_word;
  logic               rd_ok;
  logic               wr_ok;
  logic [AW-1:0]      rd_idx;
  logic [AW-1:0]      wr_idx;
  logic [WIDTH-1:0]   rd_word_data;
  logic [WIDTH:0]     fifo_in_data;
  logic [WIDTH:0]     fifo_out_data;

  logic               mem_we;
  logic [AW-1:0]      mem_idx;
  logic [WIDTH-1:0]   mem_wdata;
  logic [BYTES-1:0]   mem_be;

  // State register and clearing index; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) init_idx <= (init_idx == LAST) ? '0 : init_idx + 1'b1;
    end
  end

  // Next state plus handshake outputs. These are gated by rst so nothing is accepted during reset.
  always_comb begin
    state_next   = state;
    run          = (state == RUN) && !rst;
    init_done    = run;
    wr_ready     = run;
    rd_req_ready = run && fifo_in_ready;
    if (state == INIT && init_idx == LAST) state_next = RUN;
  end

  // Address decode for both ports: the word index, and whether it is aligned and in range.
  always_comb begin
    rd_word = rd_req_addr >> OFS;
    wr_word = wr_addr >> OFS;
    rd_ok   = ((rd_req_addr & LOW_MASK) == 32'd0) && (rd_word < DEPTH_W);
    wr_ok   = ((wr_addr & LOW_MASK) == 32'd0) && (wr_word < DEPTH_W);
    rd_idx  = rd_word[AW-1:0];
    wr_idx  = wr_word[AW-1:0];
    rd_fire = rd_req_valid && rd_req_ready;
    wr_fire = wr_valid && wr_ready;
  end

  // Read data with write-first bypass: a same-cycle write to the same word shows its strobed bytes.
  always_comb begin
    rd_word_data = mem[rd_idx];
    if (wr_fire && wr_ok && (wr_idx == rd_idx)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_strb[b]) rd_word_data[b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
    fifo_in_data = rd_ok ? {1'b0, rd_word_data} : {1'b1, {WIDTH{1'b0}}};
  end

  // Single write port shared between clearing and accepted valid writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = init_idx;
    mem_wdata = '0;
    mem_be    = '0;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_idx   = init_idx;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (wr_fire && wr_ok) begin
      mem_we    = 1'b1;
      mem_idx   = wr_idx;
      mem_wdata = wr_data;
      mem_be    = wr_strb;
    end
  end

  // Array write with per-byte enables.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_be[b]) mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // A rejected write raises wr_err for exactly the following cycle.
  always_ff @(posedge clk) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= wr_fire && !wr_ok;
  end

  rsp_fifo #(
    .DW(WIDTH + 1)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_fire),
    .in_ready (fifo_in_ready),
    .in_data  (fifo_in_data),
    .out_valid(rd_rsp_valid),
    .out_ready(rd_rsp_ready),
    .out_data (fifo_out_data)
  );

  assign rd_rsp_err  = fifo_out_data[WIDTH];
  assign rd_rsp_data = fifo_out_data[WIDTH-1:0];

endmodule

// File: tb/tb_memory_bank.sv
// Table-driven bench for memory_bank with a response scoreboard.
module tb_memory_bank;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic              clk;
  logic              rst;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [31:0]       rd_req_addr;
  logic              rd_rsp_valid;
  logic              rd_rsp_ready;
  logic [WIDTH-1:0]  rd_rsp_data;
  logic              rd_rsp_err;
  logic              wr_valid;
  logic              wr_ready;
  logic [31:0]       wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [3:0]        wr_strb;
  logic              wr_err;
  logic              init_done;

  memory_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err), .init_done(init_done)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    bit          lat;
  } rsp_t;

  typedef struct {
    bit          rd;
    logic [31:0] raddr;
    bit          wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    bit          exp_err;
    bit          exp_wr_err;
  } vec_t;

  rsp_t sb[$];
  rsp_t mon_r;
  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every consumed response.
  always @(negedge clk) begin
    if (!rst && rd_rsp_valid && rd_rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got %h expected no response", rd_rsp_data);
      end else begin
        mon_r = sb.pop_front();
        checkOutput("rsp_data", rd_rsp_data, mon_r.data);
        checkOutput("rsp_err", 32'(rd_rsp_err), 32'(mon_r.err));
        if (mon_r.lat) checkOutput("rsp_latency", 32'(cyc), 32'(mon_r.acc + 1));
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    bit ok;
    ok = 0;
    rd_req_valid = v.rd;
    rd_req_addr  = v.raddr;
    wr_valid     = v.wr;
    wr_addr      = v.waddr;
    wr_data      = v.wdata;
    wr_strb      = v.strb;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((!v.rd || rd_req_ready) && (!v.wr || wr_ready)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no handshake expected handshake within 20 cycles");
    end
    @(posedge clk);
    #1;
    rd_req_valid = 1'b0;
    wr_valid     = 1'b0;
    if (ok && v.rd) sb.push_back('{v.exp_data, v.exp_err, cyc - 1, 1'b1});
    checkOutput("wr_err", 32'(wr_err), 32'(v.exp_wr_err));
  endtask

  task automatic issueRead(input logic [31:0] addr, input logic [31:0] data,
                           input logic err, input bit lat);
    bit ok;
    ok = 0;
    rd_req_valid = 1'b1;
    rd_req_addr  = addr;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd_req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL read_timeout: got rd_req_ready=0 expected acceptance of %h", addr);
    end
    @(posedge clk);
    #1;
    rd_req_valid = 1'b0;
    if (ok) sb.push_back('{data, err, cyc - 1, lat});
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic waitInit();
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("init_low", 32'(init_done), 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("init_done", 32'(init_done), 32'd1);
    checkOutput("rd_req_ready_run", 32'(rd_req_ready), 32'd1);
    checkOutput("wr_ready_run", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h0,          32'h0,          4'h0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'h5, 32'h0000_0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0004, 1'b0, 32'h0,          32'h0,          4'h0, 32'h00AD_00EF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h0,          32'h0,          4'h0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0008, 1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF, 32'h1122_3344, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_001C, 1'b1, 32'h0000_001C, 32'hAABB_CCDD, 4'h8, 32'hAA00_0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_001C, 1'b0, 32'h0,          32'h0,          4'h0, 32'hAA00_0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004, 32'h1234_5678, 4'h2, 32'h00AD_56EF, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0003, 1'b0, 32'h0,          32'h0,          4'h0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,          32'h0,          4'h0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0020, 32'h5555_5555, 4'hF, 32'h0000_0000, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 32'h0000_0008, 1'b0, 32'h0,          32'h0,          4'h0, 32'h1122_3344, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0004, 1'b0, 32'h0,          32'h0,          4'h0, 32'h00AD_56EF, 1'b0, 1'b0};

    rst          = 1'b1;
    rd_req_valid = 1'b0;
    rd_req_addr  = 32'h0;
    rd_rsp_ready = 1'b1;
    wr_valid     = 1'b0;
    wr_addr      = 32'h0;
    wr_data      = 32'h0;
    wr_strb      = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_init_done", 32'(init_done), 32'd0);
    checkOutput("rst_rd_req_ready", 32'(rd_req_ready), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rd_rsp_data, 32'd0);
    checkOutput("rst_rsp_err", 32'(rd_rsp_err), 32'd0);
    checkOutput("rst_wr_err", 32'(wr_err), 32'd0);
    waitInit();

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);
    drain();

    $display("[TB] back-pressure with four reads");
    rd_rsp_ready = 1'b0;
    issueRead(32'h8, 32'h1122_3344, 1'b0, 1'b0);
    issueRead(32'h4, 32'h00AD_56EF, 1'b0, 1'b0);
    rd_req_valid = 1'b1;
    rd_req_addr  = 32'h1C;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_req_ready", 32'(rd_req_ready), 32'd0);
      checkOutput("stall_rsp_valid", 32'(rd_rsp_valid), 32'd1);
      checkOutput("stall_rsp_hold", rd_rsp_data, 32'h1122_3344);
    end
    @(posedge clk);
    #1;
    rd_rsp_ready = 1'b1;
    issueRead(32'h1C, 32'hAA00_0000, 1'b0, 1'b0);
    issueRead(32'h0, 32'h0000_0000, 1'b0, 1'b0);
    drain();

    $display("[TB] reset with buffered responses");
    rd_rsp_ready = 1'b0;
    issueRead(32'h8, 32'h1122_3344, 1'b0, 1'b0);
    issueRead(32'h1C, 32'hAA00_0000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("buffered_valid", 32'(rd_rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_rsp_ready = 1'b1;
    checkOutput("flush_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    checkOutput("flush_rsp_data", rd_rsp_data, 32'd0);
    waitInit();
    issueRead(32'h8, 32'h0, 1'b0, 1'b1);
    issueRead(32'h1C, 32'h0, 1'b0, 1'b1);
    issueRead(32'h4, 32'h0, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
